// File: rtl/truss_multi_watchdog.sv
// Multi-channel watchdog timer: a shared tick prescaler drives NUM_CHANNELS independent
// one-shot/periodic timeout channels, each with a saturating expiry counter.
module truss_multi_watchdog #(
    parameter int NUM_CHANNELS   = 4,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   cfg_we,
    input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [COUNTER_WIDTH-1:0]               cfg_limit,
    input  logic                                   cfg_periodic,
    input  logic                                   cfg_clr_count,
    input  logic [PRESCALE_WIDTH-1:0]              prescale,
    input  logic [NUM_CHANNELS-1:0]                arm,
    input  logic [NUM_CHANNELS-1:0]                kick,
    input  logic [NUM_CHANNELS-1:0]                ack,
    output logic [NUM_CHANNELS-1:0]                timeout,
    output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0]  hdl_timeout_count,
    output logic                                   hdl_timeout
);

    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CW     = COUNTER_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } chan_state_t;

    logic [PRESCALE_WIDTH-1:0] pre_cnt_reg, pre_cnt_next;
    logic                      tick;
    logic                      hdl_timeout_reg;

    // A counter left above a freshly lowered prescale wraps silently (no tick).
    always_comb begin
        tick         = (pre_cnt_reg == prescale);
        pre_cnt_next = pre_cnt_reg + 1'b1;
        if (pre_cnt_reg >= prescale) begin
            pre_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_reg     <= '0;
            hdl_timeout_reg <= 1'b0;
        end else begin
            pre_cnt_reg     <= pre_cnt_next;
            hdl_timeout_reg <= |timeout;
        end
    end

    assign hdl_timeout = hdl_timeout_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            chan_state_t   state_reg, state_next;
            logic [CW-1:0] cnt_reg, cnt_next;
            logic [CW-1:0] limit_reg, limit_next;
            logic [CW-1:0] exp_reg, exp_next;
            logic          periodic_reg, periodic_next;
            logic          to_reg, to_next;
            logic          cfg_hit;
            logic          at_limit;
            logic          expire_evt;
            logic [CW:0]   cnt_inc;

            // Out-of-range channel numbers never match any instance, so they are dropped.
            assign cfg_hit  = cfg_we && (cfg_chan == CHAN_W'(gi));
            assign cnt_inc  = {1'b0, cnt_reg} + {{CW{1'b0}}, 1'b1};
            // ">=" rather than "==" so a limit lowered below the running count fires next tick.
            assign at_limit = (limit_reg == '0) || (cnt_inc >= {1'b0, limit_reg});

            always_comb begin
                state_next    = state_reg;
                cnt_next      = cnt_reg;
                to_next       = 1'b0;
                expire_evt    = 1'b0;
                limit_next    = cfg_hit ? cfg_limit : limit_reg;
                periodic_next = cfg_hit ? cfg_periodic : periodic_reg;
                exp_next      = exp_reg;

                if (!arm[gi]) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end
                        ST_RUN: begin
                            if (kick[gi]) begin
                                cnt_next = '0;
                            end else if (tick) begin
                                if (at_limit) begin
                                    expire_evt = 1'b1;
                                    to_next    = 1'b1;
                                    if (periodic_reg) begin
                                        cnt_next = '0;
                                    end else begin
                                        state_next = ST_EXPIRED;
                                    end
                                end else begin
                                    cnt_next = cnt_inc[CW-1:0];
                                end
                            end
                        end
                        ST_EXPIRED: begin
                            if (ack[gi]) begin
                                state_next = ST_RUN;
                                cnt_next   = '0;
                            end else begin
                                to_next = 1'b1;
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end

                if (cfg_hit && cfg_clr_count) begin
                    exp_next = '0;
                end else if (expire_evt && (exp_reg != {CW{1'b1}})) begin
                    exp_next = exp_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg    <= ST_IDLE;
                    cnt_reg      <= '0;
                    limit_reg    <= {CW{1'b1}};
                    periodic_reg <= 1'b0;
                    exp_reg      <= '0;
                    to_reg       <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    cnt_reg      <= cnt_next;
                    limit_reg    <= limit_next;
                    periodic_reg <= periodic_next;
                    exp_reg      <= exp_next;
                    to_reg       <= to_next;
                end
            end

            assign timeout[gi]                                = to_reg;
            assign hdl_timeout_count[gi*CW +: CW]             = exp_reg;
        end
    endgenerate

endmodule

// File: tb/tb_truss_multi_watchdog.sv
// Bench for truss_multi_watchdog: directed scenarios plus randomized traffic, all
// cycle-compared against a flag/elapsed-ticks reference model.
module tb_truss_multi_watchdog;

    localparam int NC = 3;
    localparam int CW = 4;
    localparam int PW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                cfg_we = 1'b0;
    logic [1:0]          cfg_chan = '0;
    logic [CW-1:0]       cfg_limit = '0;
    logic                cfg_periodic = 1'b0;
    logic                cfg_clr_count = 1'b0;
    logic [PW-1:0]       prescale = '0;
    logic [NC-1:0]       arm = '0;
    logic [NC-1:0]       kick = '0;
    logic [NC-1:0]       ack = '0;
    logic [NC-1:0]       timeout;
    logic [NC*CW-1:0]    hdl_timeout_count;
    logic                hdl_timeout;

    truss_multi_watchdog #(
        .NUM_CHANNELS  (NC),
        .COUNTER_WIDTH (CW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cfg_we           (cfg_we),
        .cfg_chan         (cfg_chan),
        .cfg_limit        (cfg_limit),
        .cfg_periodic     (cfg_periodic),
        .cfg_clr_count    (cfg_clr_count),
        .prescale         (prescale),
        .arm              (arm),
        .kick             (kick),
        .ack              (ack),
        .timeout          (timeout),
        .hdl_timeout_count(hdl_timeout_count),
        .hdl_timeout      (hdl_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: "active"/"expired" flags and ticks elapsed since last restart.
    int m_phase;
    bit m_active[NC];
    bit m_expired[NC];
    int m_elapsed[NC];
    int m_limit[NC];
    bit m_periodic[NC];
    int m_count[NC];
    bit m_to[NC];
    bit m_hdl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int dut_count(input int ch);
        logic [NC*CW-1:0] v;
        v = hdl_timeout_count;
        return int'(v[ch*CW +: CW]);
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_hdl   = 1'b0;
        for (int i = 0; i < NC; i++) begin
            m_active[i]   = 1'b0;
            m_expired[i]  = 1'b0;
            m_elapsed[i]  = 0;
            m_limit[i]    = SAT;
            m_periodic[i] = 1'b0;
            m_count[i]    = 0;
            m_to[i]       = 1'b0;
        end
    endfunction

    function automatic void model_clock();
        bit any_prev;
        bit tk;
        bit fire;
        any_prev = 1'b0;
        for (int i = 0; i < NC; i++) any_prev |= m_to[i];
        tk = (m_phase == int'(prescale));
        m_phase = (m_phase >= int'(prescale)) ? 0 : m_phase + 1;
        for (int i = 0; i < NC; i++) begin
            fire = 1'b0;
            if (!arm[i]) begin
                m_active[i] = 0; m_expired[i] = 0; m_elapsed[i] = 0; m_to[i] = 0;
            end else if (!m_active[i]) begin
                m_active[i] = 1; m_expired[i] = 0; m_elapsed[i] = 0; m_to[i] = 0;
            end else if (m_expired[i]) begin
                if (ack[i]) begin
                    m_expired[i] = 0; m_elapsed[i] = 0; m_to[i] = 0;
                end else begin
                    m_to[i] = 1;
                end
            end else begin
                m_to[i] = 0;
                if (kick[i]) m_elapsed[i] = 0;
                else if (tk) begin
                    if (m_limit[i] == 0 || m_elapsed[i] + 1 >= m_limit[i]) fire = 1;
                    else m_elapsed[i]++;
                end
            end
            if (fire) begin
                m_to[i] = 1;
                if (m_count[i] < SAT) m_count[i]++;
                if (m_periodic[i]) m_elapsed[i] = 0;
                else m_expired[i] = 1;
            end
            if (cfg_we && int'(cfg_chan) == i) begin
                m_limit[i]    = int'(cfg_limit);
                m_periodic[i] = cfg_periodic;
                if (cfg_clr_count) m_count[i] = 0;
            end
        end
        m_hdl = any_prev;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NC; i++) begin
            check($sformatf("timeout[%0d]", i), 32'(timeout[i]), 32'(m_to[i]));
            check($sformatf("count[%0d]", i), 32'(dut_count(i)), 32'(m_count[i]));
        end
        check("hdl_timeout", 32'(hdl_timeout), 32'(m_hdl));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic cfg(input int ch, input int lim, input bit per, input bit clr);
        cfg_we = 1; cfg_chan = 2'(ch); cfg_limit = CW'(lim);
        cfg_periodic = per; cfg_clr_count = clr;
        step();
        cfg_we = 0; cfg_clr_count = 0;
    endtask

    initial begin
        int pulses[$];
        bit saw;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        reset_n = 1;

        // One-shot expiry timing, held timeout, lagging hdl_timeout
        prescale = 0;
        cfg(0, 5, 0, 0);
        arm[0] = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("oneshot_rise_k%0d", k), 32'(timeout[0]), (k == 6) ? 32'd1 : 32'd0);
        end
        check("oneshot_hdl_lag", 32'(hdl_timeout), 32'd0);
        step();
        check("oneshot_held", 32'(timeout[0]), 32'd1);
        check("oneshot_hdl", 32'(hdl_timeout), 32'd1);
        check("oneshot_count", 32'(dut_count(0)), 32'd1);

        // Periodic pulses every 6 clk with prescale=1, limit=3
        arm[0] = 0;
        prescale = 1;
        cfg(1, 3, 1, 0);
        arm[1] = 1;
        for (int k = 0; k < 40 && pulses.size() < 4; k++) begin
            step();
            if (timeout[1]) pulses.push_back(k);
        end
        check("periodic_npulses", 32'(pulses.size()), 32'd4);
        for (int p = 1; p < pulses.size(); p++)
            check($sformatf("periodic_gap%0d", p), 32'(pulses[p] - pulses[p-1]), 32'd6);
        check("periodic_count", 32'(dut_count(1)), 32'd4);

        // Regular kicks prevent expiry; kick on the expiry tick wins
        arm[1] = 0;
        prescale = 0;
        cfg(0, 4, 0, 0);
        arm[0] = 1;
        step();
        saw = 0;
        for (int t = 0; t < 100; t++) begin
            kick[0] = (t % 3 == 2);
            step();
            kick[0] = 0;
            saw |= timeout[0];
        end
        check("kick_never_expire", 32'(saw), 32'd0);
        step(); step();
        kick[0] = 1;
        step();
        kick[0] = 0;
        check("kick_on_expiry_to", 32'(timeout[0]), 32'd0);
        check("kick_on_expiry_cnt", 32'(dut_count(0)), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("reexpire_k%0d", k), 32'(timeout[0]), (k == 4) ? 32'd1 : 32'd0);
        end
        check("reexpire_count", 32'(dut_count(0)), 32'd2);

        // EXPIRED: kick ignored, ack restarts
        kick[0] = 1;
        step();
        kick[0] = 0;
        check("expired_kick_ignored", 32'(timeout[0]), 32'd1);
        ack[0] = 1;
        step();
        ack[0] = 0;
        check("ack_clears", 32'(timeout[0]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("ack_reexpire_k%0d", k), 32'(timeout[0]), (k == 4) ? 32'd1 : 32'd0);
        end
        check("ack_reexpire_count", 32'(dut_count(0)), 32'd3);

        // Saturation, then clear coinciding with an expiry
        arm[0] = 0;
        cfg(2, 1, 1, 0);
        arm[2] = 1;
        for (int k = 0; k < 21; k++) step();
        check("sat_count", 32'(dut_count(2)), 32'(SAT));
        cfg(2, 1, 1, 1);
        check("clr_wins", 32'(dut_count(2)), 32'd0);
        step();
        check("count_after_clr", 32'(dut_count(2)), 32'd1);
        arm[2] = 0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(0, 99) < 3) arm[i] = ~arm[i];
                kick[i] = ($urandom_range(0, 99) < 8);
                ack[i]  = ($urandom_range(0, 99) < 15);
            end
            if ($urandom_range(0, 99) < 2) prescale = PW'($urandom_range(0, 3));
            cfg_we        = ($urandom_range(0, 99) < 6);
            cfg_chan      = 2'($urandom_range(0, 3));
            cfg_limit     = CW'($urandom_range(0, 6));
            cfg_periodic  = 1'($urandom_range(0, 1));
            cfg_clr_count = 1'($urandom_range(0, 1));
            step();
        end
        kick = '0; ack = '0; cfg_we = 0; cfg_clr_count = 0;

        // Asynchronous reset while a one-shot timeout is held
        arm = '0;
        prescale = 0;
        step();
        cfg(0, 1, 0, 0);
        arm[0] = 1;
        for (int k = 0; k < 4; k++) step();
        check("pre_reset_held", 32'(timeout[0]), 32'd1);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check("async_rst_timeout", 32'(timeout), 32'd0);
        check("async_rst_hdl", 32'(hdl_timeout), 32'd0);
        check("async_rst_counts", 32'(hdl_timeout_count), 32'd0);
        prescale = 2;
        @(negedge clk);
        reset_n = 1;
        for (int k = 0; k < 60; k++) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/truss_multi_watchdog.md
TRUSS_MULTI_WATCHDOG -- requirements
Module: truss_multi_watchdog

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent watchdog channels, range 1..16.
REQ-002 Parameter COUNTER_WIDTH, default 32: width of each channel's timeout counter, limit and expiry-count fields.
REQ-003 Parameter PRESCALE_WIDTH, default 8: width of the shared tick prescaler.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port cfg_we  input  1  configuration write strobe, one cycle per write.
REQ-007 Port cfg_chan  input  $clog2(NUM_CHANNELS) (min 1)  target channel of cfg_we.
REQ-008 Port cfg_limit  input  COUNTER_WIDTH  timeout limit in ticks for the target channel.
REQ-009 Port cfg_periodic  input  1  target channel mode: 0 = one-shot, 1 = periodic.
REQ-010 Port cfg_clr_count  input  1  with cfg_we, zero the target channel's expiry count.
REQ-011 Port prescale  input  PRESCALE_WIDTH  global tick divider; tick every prescale+1 clk cycles.
REQ-012 Port arm  input  NUM_CHANNELS  level per channel; 1 = channel enabled.
REQ-013 Port kick  input  NUM_CHANNELS  one-cycle pulse per channel; restarts that channel's count.
REQ-014 Port ack  input  NUM_CHANNELS  one-cycle pulse per channel; clears a held one-shot expiry.
REQ-015 Port timeout  output  NUM_CHANNELS  per-channel expiry indication.
REQ-016 Port hdl_timeout_count  output  NUM_CHANNELS*COUNTER_WIDTH  packed per-channel expiry counts, channel 0 in LSBs.
REQ-017 Port hdl_timeout  output  1  OR of all timeout bits, registered.

Function
REQ-018 Prescaler: free-running counter, 0..prescale; tick asserted for one clk when counter equals prescale, then wraps to 0; prescale=0 gives tick every cycle.
REQ-019 Change of prescale mid-count: if counter > new prescale, counter wraps to 0 next cycle without asserting tick.
REQ-020 Per-channel FSM states IDLE, RUN, EXPIRED; reset state IDLE.
REQ-021 IDLE -> RUN when arm=1; counter loaded with 0.
REQ-022 Any state -> IDLE when arm=0; counter cleared, timeout deasserted next cycle; expiry count retained.
REQ-023 RUN: on tick, counter increments; when counter+1 equals limit (or limit=0) expiry occurs instead of increment.
REQ-024 Expiry, one-shot: -> EXPIRED, timeout=1 held, counter frozen, expiry count incremented once.
REQ-025 Expiry, periodic: stay RUN, counter reloaded to 0, timeout=1 for exactly one clk, expiry count incremented.
REQ-026 EXPIRED -> RUN with counter 0 on ack (timeout cleared same edge); kick in EXPIRED is ignored.
REQ-027 kick in RUN: counter set to 0; kick and expiry on the same cycle: kick wins, no expiry, count unchanged.
REQ-028 Expiry count saturates at all-ones; never wraps.
REQ-029 cfg_we: limit and mode of cfg_chan written at that edge; counter not reset; if running counter >= new limit, expiry occurs on the next tick.
REQ-030 cfg_we with cfg_clr_count=1 and coincident expiry on the same channel: count becomes 0 (clear wins).
REQ-031 cfg_chan >= NUM_CHANNELS: write ignored.
REQ-032 hdl_timeout lags the OR of timeout by exactly one clk.
REQ-033 Channels fully independent except shared tick and configuration port.

Reset
REQ-034 reset_n low asynchronously forces: all FSMs IDLE, counters 0, limits all-ones, mode one-shot, prescaler 0, expiry counts 0, timeout 0, hdl_timeout 0.
REQ-035 Reset deassertion mid-operation: first tick occurs prescale+1 clk after release; armed channels enter RUN on first clk after release.

Verification
REQ-036 prescale=0, ch0 limit=5 one-shot, arm[0]=1 -> timeout[0] rises 6 clk after arm, held; count0=1; hdl_timeout one clk later.
REQ-037 ch1 limit=3 periodic, prescale=1 -> timeout[1] one-clk pulses every 6 clk; count1=4 after four pulses.
REQ-038 ch0 limit=4, kick every 3 ticks for 100 ticks -> timeout[0] never asserts; kick on the expiry tick -> no expiry.
REQ-039 Channel in EXPIRED: kick ignored, ack -> timeout clears, count restarts, re-expires after limit ticks.
REQ-040 COUNTER_WIDTH=4, limit=1 periodic for 20 ticks -> count saturates at 15; cfg_clr_count -> 0.
REQ-041 reset_n low mid-RUN with timeout held -> all outputs 0 asynchronously, before next clk edge.
